// File: rtl/board_ram_arbiter.sv
// rtl/board_ram_arbiter.sv - req/grant arbiter for the single-port board RAM
//
// Shares ram_board between the board-access engines (collision check, piece
// commit, row clear, redraw, clear). One requester owns the RAM at a time; the
// owner's address/data/wren are muxed straight onto the RAM port, and reads
// come back tagged with a one-hot valid strobe RD_LAT cycles later.
//
// Build option: BOARD_ARB_RR_EN selects round-robin winner selection. Without
// it, the lowest requesting index wins and no pointer register exists.
//
// Ports:
//   i_clk        system clock
//   i_reset_n    asynchronous active-low reset
//   i_req        per-requester request, held for the whole ownership period
//   i_req_addr   flattened addresses, slice i belongs to requester i
//   i_req_data   flattened write data, slice i belongs to requester i
//   i_req_wren   per-requester write enable
//   o_grant      registered one-hot grant (or zero)
//   o_ram_addr   RAM address (0 while nobody owns the RAM)
//   o_ram_data   RAM write data (0 while nobody owns the RAM)
//   o_ram_wren   RAM write enable
//   i_ram_q      RAM read data
//   o_rd_valid   one-hot read-return strobe naming the requester that issued the read
//   o_rd_data    read data, ram_q passthrough
//   o_busy       high whenever a grant is held
module board_ram_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic [NREQ-1:0]          i_req,
    input  logic [NREQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NREQ*DATA_W-1:0]   i_req_data,
    input  logic [NREQ-1:0]          i_req_wren,
    output logic [NREQ-1:0]          o_grant,
    output logic [ADDR_W-1:0]        o_ram_addr,
    output logic [DATA_W-1:0]        o_ram_data,
    output logic                     o_ram_wren,
    input  logic [DATA_W-1:0]        i_ram_q,
    output logic [NREQ-1:0]          o_rd_valid,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic                     o_busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_OWNED = 1'b1;

    logic [0:0]       r_state;
    logic [NREQ-1:0]  r_grant;
    logic [NREQ-1:0]  r_tag [RD_LAT];

    logic [IDX_W-1:0] w_owner_idx;
    logic             w_owner_req;
    logic             w_hold;
    logic [NREQ-1:0]  w_cand;
    logic [NREQ-1:0]  w_win;
    logic [NREQ-1:0]  w_grant_nxt;
    logic [NREQ-1:0]  w_push_tag;
    logic             w_ram_wren;

    // Grant is one-hot, so the encoder simply picks the set bit.
    always_comb begin
        w_owner_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_owner_idx = IDX_W'(i);
            end
        end
    end

    assign w_owner_req = |(i_req & r_grant);
    assign w_hold      = (r_state == S_OWNED) && w_owner_req;

    // While the owner is releasing, it is excluded so another pending
    // requester takes over in the very next cycle.
    always_comb begin
        w_cand = i_req;
        if (r_state == S_OWNED) begin
            w_cand = i_req & ~r_grant;
        end
    end

`ifdef BOARD_ARB_RR_EN
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_found;
    int               w_scan_idx;

    // Search starts at the pointer and wraps from NREQ-1 back to 0.
    always_comb begin
        w_win      = '0;
        w_win_idx  = '0;
        w_found    = 1'b0;
        w_scan_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan_idx = int'(r_rr_ptr) + k;
            if (w_scan_idx >= NREQ) begin
                w_scan_idx = w_scan_idx - NREQ;
            end
            if (!w_found && w_cand[IDX_W'(w_scan_idx)]) begin
                w_found   = 1'b1;
                w_win_idx = IDX_W'(w_scan_idx);
            end
        end
        if (w_found) begin
            w_win[w_win_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rr_ptr <= '0;
        end else if (!w_hold && w_found) begin
            if (w_win_idx == IDX_W'(NREQ - 1)) begin
                r_rr_ptr <= '0;
            end else begin
                r_rr_ptr <= w_win_idx + IDX_W'(1);
            end
        end
    end
`else
    // Isolate the lowest set bit: lowest index wins.
    assign w_win = w_cand & (~w_cand + NREQ'(1));
`endif

    assign w_grant_nxt = w_hold ? r_grant : w_win;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_grant <= '0;
            r_state <= S_IDLE;
        end else begin
            r_grant <= w_grant_nxt;
            r_state <= (|w_grant_nxt) ? S_OWNED : S_IDLE;
        end
    end

    // The write is gated by the owner's live req so a write presented in
    // the release cycle never reaches the RAM.
    assign w_ram_wren = i_req_wren[w_owner_idx] & i_req[w_owner_idx] & r_grant[w_owner_idx];

    assign o_ram_addr = (|r_grant) ? i_req_addr[w_owner_idx*ADDR_W +: ADDR_W] : '0;
    assign o_ram_data = (|r_grant) ? i_req_data[w_owner_idx*DATA_W +: DATA_W] : '0;
    assign o_ram_wren = w_ram_wren;

    // Read tags follow the RAM latency; write cycles push an empty tag.
    assign w_push_tag = w_ram_wren ? '0 : (r_grant & i_req);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_push_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign o_grant    = r_grant;
    assign o_busy     = |r_grant;
    assign o_rd_valid = r_tag[RD_LAT-1];
    assign o_rd_data  = i_ram_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb/tb_board_ram_arbiter.sv - directed self-checking bench for board_ram_arbiter
module tb_board_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_addr;
    logic [23:0] req_data;
    logic [3:0]  req_wren;

    logic [3:0]  grant1, grant2, rdv1, rdv2;
    logic [7:0]  addr1, addr2;
    logic [5:0]  data1, data2, q1, q2, q2a, rdd1, rdd2;
    logic        wren1, wren2, busy1, busy2;

    logic [5:0]  mem  [256];
    logic [5:0]  mem2 [256];

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_g;

    always #5 clk = ~clk;

    board_ram_arbiter #(.NREQ(4), .ADDR_W(8), .DATA_W(6), .RD_LAT(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_req_addr(req_addr),
        .i_req_data(req_data), .i_req_wren(req_wren), .o_grant(grant1),
        .o_ram_addr(addr1), .o_ram_data(data1), .o_ram_wren(wren1),
        .i_ram_q(q1), .o_rd_valid(rdv1), .o_rd_data(rdd1), .o_busy(busy1)
    );

    board_ram_arbiter #(.NREQ(4), .ADDR_W(8), .DATA_W(6), .RD_LAT(2)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .i_req(req), .i_req_addr(req_addr),
        .i_req_data(req_data), .i_req_wren(req_wren), .o_grant(grant2),
        .o_ram_addr(addr2), .o_ram_data(data2), .o_ram_wren(wren2),
        .i_ram_q(q2), .o_rd_valid(rdv2), .o_rd_data(rdd2), .o_busy(busy2)
    );

    // RAM models: 1-cycle registered read for dut1, 2-cycle for dut2.
    always @(posedge clk) begin
        if (wren1) mem[addr1] <= data1;
        q1 <= mem[addr1];
    end

    always @(posedge clk) begin
        if (wren2) mem2[addr2] <= data2;
        q2a <= mem2[addr2];
        q2  <= q2a;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_slice(input int i, input logic [7:0] a, input logic [5:0] d, input logic w);
        req_addr[i*8 +: 8] = a;
        req_data[i*6 +: 6] = d;
        req_wren[i]        = w;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = '0;
            mem2[i] = '0;
        end
        mem[8'h10]  = 6'h33;
        mem2[8'h20] = 6'h2C;
        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        req_wren = '0;

        // Reset state
        tick();
        tick();
        chk("rst_grant", grant1, 4'b0000);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_rdv", rdv1, 4'b0000);
        chk("rst_wren", wren1, 1'b0);
        chk("rst_addr", addr1, 8'h00);
        chk("rst_data", data1, 6'h00);
        rst_n = 1'b1;
        tick();

        // Single requester write
        set_slice(2, 8'h15, 6'h2A, 1'b1);
        req = 4'b0100;
        settle();
        chk("t1_latency", grant1, 4'b0000);
        tick(); settle();
        chk("t1_grant", grant1, 4'b0100);
        chk("t1_wren", wren1, 1'b1);
        chk("t1_addr", addr1, 8'h15);
        chk("t1_data", data1, 6'h2A);
        chk("t1_busy", busy1, 1'b1);
        tick(); settle();
        chk("t1_write_no_rdv", rdv1, 4'b0000);
        req = 4'b0000;
        settle();
        chk("t1_drop_wren_suppressed", wren1, 1'b0);
        chk("t1_drop_grant_held", grant1, 4'b0100);
        tick(); settle();
        chk("t1_release_grant", grant1, 4'b0000);
        chk("t1_release_busy", busy1, 1'b0);

        // Read return, RD_LAT=1
        set_slice(2, 8'h00, 6'h00, 1'b0);
        set_slice(1, 8'h10, 6'h00, 1'b0);
        req = 4'b0010;
        tick(); settle();
        chk("t2_grant", grant1, 4'b0010);
        chk("t2_read_wren", wren1, 1'b0);
        chk("t2_addr", addr1, 8'h10);
        tick();
        set_slice(1, 8'h10, 6'h05, 1'b1);
        settle();
        chk("t2_rdv", rdv1, 4'b0010);
        chk("t2_rdata", rdd1, 6'h33);
        tick(); settle();
        chk("t2_write_no_rdv", rdv1, 4'b0000);
        req = 4'b0000;
        tick(); settle();
        chk("t2_release", grant1, 4'b0000);

        // Contention, non-owner wren ignored, handoff without idle cycle
        set_slice(1, 8'h01, 6'h00, 1'b0);
        set_slice(3, 8'h03, 6'h11, 1'b1);
        req = 4'b1010;
        tick(); settle();
        chk("t3_grant", grant1, 4'b0010);
        chk("t3_nonowner_wren", wren1, 1'b0);
        chk("t3_owner_data", data1, 6'h00);
        tick();
        tick();
        req = 4'b1000;
        settle();
        chk("t3_drop_hold", grant1, 4'b0010);
        tick(); settle();
        chk("t3_handoff_grant", grant1, 4'b1000);
        chk("t3_handoff_wren", wren1, 1'b1);
        chk("t3_handoff_data", data1, 6'h11);
        chk("t3_handoff_rdv", rdv1, 4'b0000);
        tick(); settle();
        chk("t3_write_no_rdv", rdv1, 4'b0000);
        req = 4'b0000;
        set_slice(3, 8'h00, 6'h00, 1'b0);
        tick(); settle();
        chk("t3_release", grant1, 4'b0000);

        // Req drops in the cycle its grant appears
        set_slice(0, 8'h05, 6'h3F, 1'b1);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        settle();
        chk("t4_grant", grant1, 4'b0001);
        chk("t4_no_write", wren1, 1'b0);
        tick(); settle();
        chk("t4_grant_gone", grant1, 4'b0000);
        chk("t4_no_rdv", rdv1, 4'b0000);
        set_slice(0, 8'h00, 6'h00, 1'b0);

        // Arbitration policy: requesters 0 and 3 repeatedly collide from idle
        for (int r = 0; r < 4; r++) begin
            req = 4'b1001;
            tick(); settle();
`ifdef BOARD_ARB_RR_EN
            exp_g = (r % 2 == 0) ? 4'b1000 : 4'b0001;
`else
            exp_g = 4'b0001;
`endif
            chk($sformatf("t5_round%0d", r), grant1, exp_g);
            tick();
            req = 4'b0000;
            tick(); settle();
            chk($sformatf("t5_idle%0d", r), grant1, 4'b0000);
        end

        // Handoff with a read in flight, RD_LAT=2
        set_slice(0, 8'h20, 6'h00, 1'b0);
        set_slice(2, 8'h22, 6'h0A, 1'b1);
        req = 4'b0001;
        tick();
        req = 4'b0101;
        settle();
        chk("t6_grant", grant2, 4'b0001);
        tick();
        req = 4'b0100;
        settle();
        chk("t6_lat1_rdv", rdv1, 4'b0001);
        chk("t6_lat2_not_yet", rdv2, 4'b0000);
        tick(); settle();
        chk("t6_new_grant", grant2, 4'b0100);
        chk("t6_lat2_rdv", rdv2, 4'b0001);
        chk("t6_lat2_rdata", rdd2, 6'h2C);
        tick(); settle();
        chk("t6_drop_no_rdv", rdv2, 4'b0000);
        req = 4'b0000;
        set_slice(2, 8'h00, 6'h00, 1'b0);
        tick(); settle();
        chk("t6_release", grant2, 4'b0000);

        // Async reset mid-ownership with reads pending
        set_slice(1, 8'h10, 6'h00, 1'b0);
        req = 4'b0010;
        tick(); settle();
        chk("t7_grant", grant1, 4'b0010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_grant", grant1, 4'b0000);
        chk("t7_rst_busy", busy1, 1'b0);
        chk("t7_rst_wren", wren1, 1'b0);
        chk("t7_rst_addr", addr1, 8'h00);
        chk("t7_rst_rdv1", rdv1, 4'b0000);
        chk("t7_rst_rdv2", rdv2, 4'b0000);
        tick(); settle();
        chk("t7_rst_rdv1_later", rdv1, 4'b0000);
        chk("t7_rst_rdv2_later", rdv2, 4'b0000);
        chk("t7_rst_grant_later", grant2, 4'b0000);
        tick();
        rst_n = 1'b1;
        settle();
        chk("t7_release_cycle", grant1, 4'b0000);
        tick(); settle();
        chk("t7_first_grant", grant1, 4'b0010);
        req = 4'b0000;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
